register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 116 +++++++++++
 tb/tb_register_file.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with rename tags (busy/dep) for an out-of-order core.
// Optional same-cycle commit forwarding to the query ports is compiled in with RF_BYPASS_EN.
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

module register_file (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      clear_in,
    input  logic                      issue_req,
    input  logic [4:0]                issue_rd,
    input  logic [`ROB_INDEX_BIT-1:0] issue_rob_id,
    input  logic [4:0]                commit_rd,
    input  logic [31:0]               commit_val,
    input  logic [`ROB_INDEX_BIT-1:0] commit_rob_id,
    input  logic [4:0]                rs1_idx,
    input  logic [4:0]                rs2_idx,
    output logic [31:0]               rs1_val,
    output logic [31:0]               rs2_val,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [`ROB_INDEX_BIT-1:0] rs1_dep,
    output logic [`ROB_INDEX_BIT-1:0] rs2_dep
);

    localparam int unsigned NREG = 32;
    localparam int unsigned XLEN = 32;
    localparam int unsigned TW   = `ROB_INDEX_BIT;

    logic [XLEN-1:0] r_val  [NREG];
    logic [NREG-1:0] r_busy;
    logic [TW-1:0]   r_dep  [NREG];

    logic w_commit_wr;
    logic w_commit_tag;
    logic w_issue;

    // A flush still lets the committing instruction retire its value.
    assign w_commit_wr  = (rdy_in | clear_in) & (commit_rd != 5'd0);
    assign w_commit_tag = rdy_in & (commit_rd != 5'd0) & (r_dep[commit_rd] == commit_rob_id);
    assign w_issue      = rdy_in & ~clear_in & issue_req & (issue_rd != 5'd0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_val[i] <= '0;
                r_dep[i] <= '0;
            end
        end else begin
            if (w_commit_wr) begin
                r_val[commit_rd] <= commit_val;
            end
            if (clear_in) begin
                r_busy <= '0;
                for (int unsigned i = 0; i < NREG; i++) begin
                    r_dep[i] <= '0;
                end
            end else begin
                if (w_commit_tag) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                // Issue is written last so a same-register rename keeps the register busy.
                if (w_issue) begin
                    r_busy[issue_rd] <= 1'b1;
                    r_dep[issue_rd]  <= issue_rob_id;
                end
            end
        end
    end

`ifdef RF_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1 = rdy_in & (commit_rd == rs1_idx) & r_busy[rs1_idx]
                  & (r_dep[rs1_idx] == commit_rob_id);
    assign w_fwd2 = rdy_in & (commit_rd == rs2_idx) & r_busy[rs2_idx]
                  & (r_dep[rs2_idx] == commit_rob_id);
`endif

    // Operand query; x0 is hard-wired to zero / not busy.
    always_comb begin
        rs1_val  = '0;
        rs1_busy = 1'b0;
        rs1_dep  = '0;
        rs2_val  = '0;
        rs2_busy = 1'b0;
        rs2_dep  = '0;
        if (rs1_idx != 5'd0) begin
            rs1_val  = r_val[rs1_idx];
            rs1_busy = r_busy[rs1_idx];
            rs1_dep  = r_dep[rs1_idx];
`ifdef RF_BYPASS_EN
            if (w_fwd1) begin
                rs1_val  = commit_val;
                rs1_busy = 1'b0;
            end
`endif
        end
        if (rs2_idx != 5'd0) begin
            rs2_val  = r_val[rs2_idx];
            rs2_busy = r_busy[rs2_idx];
            rs2_dep  = r_dep[rs2_idx];
`ifdef RF_BYPASS_EN
            if (w_fwd2) begin
                rs2_val  = commit_val;
                rs2_busy = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based reference model.
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

module tb_register_file;

    localparam int unsigned TW = `ROB_INDEX_BIT;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          rdy_in;
    logic          clear_in;
    logic          issue_req;
    logic [4:0]    issue_rd;
    logic [TW-1:0] issue_rob_id;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_val;
    logic [TW-1:0] commit_rob_id;
    logic [4:0]    rs1_idx;
    logic [4:0]    rs2_idx;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [TW-1:0] rs1_dep;
    logic [TW-1:0] rs2_dep;

    int total = 0;
    int bad   = 0;

    logic [31:0]   m_val  [32];
    logic          m_busy [32];
    logic [TW-1:0] m_dep  [32];

    register_file dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .issue_req(issue_req), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_dep(rs1_dep), .rs2_dep(rs2_dep)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_dep[i]  = '0;
        end
    endtask

    // Architectural effect of one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        logic hit;
        if (!rst_n_in) return;
        hit = (commit_rd != 0) && (m_dep[commit_rd] == commit_rob_id);
        if ((rdy_in || clear_in) && commit_rd != 0) m_val[commit_rd] = commit_val;
        if (clear_in) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 1'b0;
                m_dep[i]  = '0;
            end
        end else if (rdy_in) begin
            if (hit) m_busy[commit_rd] = 1'b0;
            if (issue_req && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
                m_dep[issue_rd]  = issue_rob_id;
            end
        end
    endtask

    task automatic check_port(input string nm, input logic [4:0] idx, input logic [31:0] v,
                              input logic b, input logic [TW-1:0] d);
        logic [31:0]   ev;
        logic          eb;
        logic [TW-1:0] ed;
        logic          dep_valid;
        if (!rst_n_in || idx == 0) begin
            ev = '0; eb = 1'b0; ed = '0; dep_valid = 1'b1;
        end else begin
            ev = m_val[idx]; eb = m_busy[idx]; ed = m_dep[idx]; dep_valid = eb;
`ifdef RF_BYPASS_EN
            if (rdy_in && commit_rd == idx && eb && ed == commit_rob_id) begin
                ev = commit_val; eb = 1'b0; dep_valid = 1'b0;
            end
`endif
        end
        chk({nm, "_val"}, v, ev);
        chk({nm, "_busy"}, 32'(b), 32'(eb));
        if (dep_valid) chk({nm, "_dep"}, 32'(d), 32'(ed));
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk_in) begin
        check_port("rs1", rs1_idx, rs1_val, rs1_busy, rs1_dep);
        check_port("rs2", rs2_idx, rs2_val, rs2_busy, rs2_dep);
    end

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; clear_in = 1'b0; issue_req = 1'b0;
        issue_rd = '0; issue_rob_id = '0; commit_rd = '0; commit_val = '0; commit_rob_id = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [TW-1:0] id);
        idle();
        issue_req = 1'b1; issue_rd = rd; issue_rob_id = id;
        tick();
    endtask

    initial begin
        model_zero();
        rst_n_in = 1'b0;
        idle();
        rs1_idx = 5'd5; rs2_idx = 5'd0;
        #12;
        chk("reset_val", rs1_val, 32'h0);
        chk("reset_busy", 32'(rs1_busy), 32'h0);
        tick();
        rst_n_in = 1'b1;

        // Rename then commit x5.
        issue(5'd5, TW'(3));
        idle(); rs1_idx = 5'd5; #1;
        chk("x5_busy", 32'(rs1_busy), 32'h1);
        chk("x5_dep", 32'(rs1_dep), 32'h3);
        commit_rd = 5'd5; commit_val = 32'h1234; commit_rob_id = TW'(3);
        tick();
        idle(); #1;
        chk("x5_val", rs1_val, 32'h1234);
        chk("x5_busy_clr", 32'(rs1_busy), 32'h0);

        // Stale-tag commit keeps the newer rename.
        issue(5'd7, TW'(2));
        issue(5'd7, TW'(4));
        idle(); commit_rd = 5'd7; commit_val = 32'hAA; commit_rob_id = TW'(2);
        tick();
        idle(); rs1_idx = 5'd7; #1;
        chk("x7_val", rs1_val, 32'hAA);
        chk("x7_busy", 32'(rs1_busy), 32'h1);
        chk("x7_dep", 32'(rs1_dep), 32'h4);

        // x0 is immutable.
        idle(); issue_req = 1'b1; issue_rd = 5'd0; issue_rob_id = TW'(1);
        commit_rd = 5'd0; commit_val = 32'hFFFF_FFFF;
        tick();
        idle(); rs1_idx = 5'd0; rs2_idx = 5'd0; #1;
        chk("x0_val", rs1_val, 32'h0);
        chk("x0_busy", 32'(rs2_busy), 32'h0);

        // Flush with a same-cycle commit and an ignored issue.
        issue(5'd1, TW'(1));
        issue(5'd2, TW'(2));
        issue(5'd3, TW'(5));
        idle(); clear_in = 1'b1; commit_rd = 5'd9; commit_val = 32'h55;
        issue_req = 1'b1; issue_rd = 5'd10; issue_rob_id = TW'(7);
        tick();
        idle(); rs1_idx = 5'd2; rs2_idx = 5'd9; #1;
        chk("clr_x2_busy", 32'(rs1_busy), 32'h0);
        chk("clr_x9_val", rs2_val, 32'h55);
        rs1_idx = 5'd10; #1;
        chk("clr_x10_busy", 32'(rs1_busy), 32'h0);

        // Paused cycle ignores issue/commit; flush still wins while paused.
        idle(); rdy_in = 1'b0; issue_req = 1'b1; issue_rd = 5'd11; issue_rob_id = TW'(1);
        commit_rd = 5'd11; commit_val = 32'h77;
        tick();
        idle(); rs1_idx = 5'd11; #1;
        chk("pause_busy", 32'(rs1_busy), 32'h0);
        chk("pause_val", rs1_val, 32'h0);
        issue(5'd12, TW'(3));
        idle(); rdy_in = 1'b0; clear_in = 1'b1;
        tick();
        idle(); rs1_idx = 5'd12; #1;
        chk("pause_clr_busy", 32'(rs1_busy), 32'h0);

        // Same-cycle commit of a busy register (forwarding when compiled in).
        issue(5'd4, TW'(6));
        idle(); commit_rd = 5'd4; commit_val = 32'hBEEF; commit_rob_id = TW'(6); rs2_idx = 5'd4; #1;
`ifdef RF_BYPASS_EN
        chk("byp_val", rs2_val, 32'hBEEF);
        chk("byp_busy", 32'(rs2_busy), 32'h0);
`else
        chk("nobyp_busy", 32'(rs2_busy), 32'h1);
`endif
        tick();
        idle(); #1;
        chk("x4_val", rs2_val, 32'hBEEF);
        chk("x4_busy", 32'(rs2_busy), 32'h0);

        // Asynchronous reset mid-sequence.
        issue(5'd8, TW'(5));
        idle(); rs1_idx = 5'd8; #1;
        chk("x8_busy_pre", 32'(rs1_busy), 32'h1);
        #1;
        rst_n_in = 1'b0;
        model_zero();
        #1;
        chk("arst_val", rs1_val, 32'h0);
        chk("arst_busy", 32'(rs1_busy), 32'h0);
        issue_req = 1'b1; issue_rd = 5'd8; issue_rob_id = TW'(2);
        commit_rd = 5'd8; commit_val = 32'hDEAD;
        tick();
        idle(); rst_n_in = 1'b1; #1;
        chk("post_rst_val", rs1_val, 32'h0);

        // Randomized traffic concentrated on a few registers.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] crd;
            rdy_in        = ($urandom_range(0, 7) != 0);
            clear_in      = ($urandom_range(0, 40) == 0);
            issue_req     = $urandom_range(0, 1) == 1;
            issue_rd      = 5'($urandom_range(0, 7));
            issue_rob_id  = TW'($urandom);
            crd           = 5'($urandom_range(0, 7));
            commit_rd     = crd;
            commit_val    = $urandom;
            commit_rob_id = ($urandom_range(0, 3) != 0) ? m_dep[crd] : TW'($urandom);
            rs1_idx       = ($urandom_range(0, 2) == 0) ? crd : 5'($urandom_range(0, 7));
            rs2_idx       = ($urandom_range(0, 2) == 0) ? crd : 5'($urandom_range(0, 31));
            tick();
        end

        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
